// File: rtl/maze_datapath_if.sv
// Control/status bundle between the maze game FSM and its datapath.
// master: FSM side (drives enables/selects, reads status).
// slave : datapath side (obeys strobes, returns status).
interface maze_datapath_if;
  logic       en_xpos;
  logic [1:0] s_xpos;
  logic       en_ypos;
  logic [1:0] s_ypos;
  logic       en_key;
  logic       s_key;
  logic       en_obs;
  logic [2:0] s_obs;
  logic       en_timer;
  logic       s_timer;
  logic       plot;
  logic [1:0] s_color;
  logic       timer_done;
  logic [2:0] move;
  logic       obs_wall;
  logic       obs_lava;
  logic       obs_ice;
  logic       unfrozen;

  modport master (
    output en_xpos, s_xpos, en_ypos, s_ypos, en_key, s_key, en_obs, s_obs,
           en_timer, s_timer, plot, s_color,
    input  timer_done, move, obs_wall, obs_lava, obs_ice, unfrozen
  );

  modport slave (
    input  en_xpos, s_xpos, en_ypos, s_ypos, en_key, s_key, en_obs, s_obs,
           en_timer, s_timer, plot, s_color,
    output timer_done, move, obs_wall, obs_lava, obs_ice, unfrozen
  );
endinterface

// File: rtl/maze_datapath.sv
// Maze game datapath: player position, tick timer, key latch, freeze counter,
// obstacle-ROM lookup and one registered pixel write per plot strobe.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   ctl             FSM control strobes in / status out (maze_datapath_if.slave)
//   key_n           pushbuttons, active-low: [3] left [2] right [1] up [0] down
//   obs_data        obstacle ROM data (1-cycle registered read of obs_addr)
//   obs_addr        obstacle ROM address (registered)
//   vga_x/y/colour  pixel write coordinates and colour, vga_plot write strobe
module maze_datapath #(
  parameter int GRID_W       = 20,
  parameter int GRID_H       = 15,
  parameter int X_W          = 5,
  parameter int Y_W          = 4,
  parameter int ADDR_W       = 9,
  parameter int START_X      = 1,
  parameter int START_Y      = 1,
  parameter int TICK_CYCLES  = 5000000,
  parameter int TICK_W       = 23,
  parameter int FREEZE_TICKS = 4
) (
  input  logic              clk,
  input  logic              reset,
  maze_datapath_if.slave    ctl,
  input  logic [3:0]        key_n,
  input  logic [1:0]        obs_data,
  output logic [ADDR_W-1:0] obs_addr,
  output logic [X_W-1:0]    vga_x,
  output logic [Y_W-1:0]    vga_y,
  output logic [2:0]        vga_colour,
  output logic              vga_plot
);
  localparam int FZ_W = $clog2(FREEZE_TICKS + 1);
  localparam logic [X_W-1:0]    X_MAX   = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]    Y_MAX   = Y_W'(GRID_H - 1);
  localparam logic [TICK_W-1:0] T_LAST  = TICK_W'(TICK_CYCLES - 1);
  localparam logic [FZ_W-1:0]   FZ_MAX  = FZ_W'(FREEZE_TICKS);
  localparam logic [ADDR_W-1:0] ADDR_RST = ADDR_W'(START_Y * GRID_W + START_X);

  logic [X_W-1:0]    xpos_q, xpos_d, tx;
  logic [Y_W-1:0]    ypos_q, ypos_d, ty;
  logic [TICK_W-1:0] timer_q, timer_d;
  logic [3:0]        key_q, key_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d, pipe_q, pipe_d, oob_q, oob_d, toob, tdir;
  logic [FZ_W-1:0]   frz_q, frz_d;
  logic [X_W-1:0]    vx_q, vx_d;
  logic [Y_W-1:0]    vy_q, vy_d;
  logic [2:0]        vc_q, vc_d, col;
  logic              vp_q;

  // Target cell of a lookup; toob flags a step off the grid edge.
  always_comb begin
    tx   = xpos_q;
    ty   = ypos_q;
    toob = 1'b0;
    tdir = 1'b1;
    case (ctl.s_obs)
      3'd1:    if (xpos_q == '0)    toob = 1'b1; else tx = xpos_q - X_W'(1);
      3'd2:    if (xpos_q == X_MAX) toob = 1'b1; else tx = xpos_q + X_W'(1);
      3'd3:    if (ypos_q == '0)    toob = 1'b1; else ty = ypos_q - Y_W'(1);
      3'd4:    if (ypos_q == Y_MAX) toob = 1'b1; else ty = ypos_q + Y_W'(1);
      default: tdir = 1'b0;  // 0 and 5..7: current cell, no result flagged
    endcase
  end

  always_comb begin
    case (ctl.s_color)
      2'd0:    col = 3'b000;
      2'd1:    col = 3'b111;
      2'd2:    col = 3'b011;
      default: col = 3'b100;
    endcase
  end

  always_comb begin
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    timer_d = timer_q;
    key_d   = key_q;
    addr_d  = addr_q;
    valid_d = pipe_q;
    pipe_d  = pipe_q;
    oob_d   = oob_q;
    frz_d   = frz_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    vc_d    = vc_q;

    if (ctl.en_xpos)
      case (ctl.s_xpos)
        2'd0: xpos_d = X_W'(START_X);
        2'd1: if (xpos_q != X_MAX) xpos_d = xpos_q + X_W'(1);
        2'd2: if (xpos_q != '0)    xpos_d = xpos_q - X_W'(1);
        default: ;
      endcase
    if (ctl.en_ypos)
      case (ctl.s_ypos)
        2'd0: ypos_d = Y_W'(START_Y);
        2'd1: if (ypos_q != Y_MAX) ypos_d = ypos_q + Y_W'(1);
        2'd2: if (ypos_q != '0)    ypos_d = ypos_q - Y_W'(1);
        default: ;
      endcase

    if (ctl.en_timer)
      timer_d = (!ctl.s_timer || ctl.timer_done) ? '0 : timer_q + TICK_W'(1);

    if (ctl.en_key) key_d = ctl.s_key ? ~key_n : 4'b0000;

    if (ctl.en_obs) begin
      // Off-grid targets skip the ROM access; the address holds.
      if (!toob) addr_d = ADDR_W'(ty) * ADDR_W'(GRID_W) + ADDR_W'(tx);
      oob_d   = toob;
      valid_d = 1'b0;
      pipe_d  = tdir;
      frz_d   = '0;
    end else if (ctl.obs_ice && ctl.timer_done && ctl.en_timer && ctl.s_timer
                 && frz_q != FZ_MAX) begin
      frz_d = frz_q + FZ_W'(1);
    end

    // Plot samples the position before any same-cycle update.
    if (ctl.plot) begin
      vx_d = xpos_q;
      vy_d = ypos_q;
      vc_d = col;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xpos_q  <= X_W'(START_X);
      ypos_q  <= Y_W'(START_Y);
      timer_q <= '0;
      key_q   <= '0;
      addr_q  <= ADDR_RST;
      valid_q <= 1'b0;
      pipe_q  <= 1'b0;
      oob_q   <= 1'b0;
      frz_q   <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
      vp_q    <= 1'b0;
    end else begin
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      timer_q <= timer_d;
      key_q   <= key_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      pipe_q  <= pipe_d;
      oob_q   <= oob_d;
      frz_q   <= frz_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
      vp_q    <= ctl.plot;
    end
  end

  always_comb begin
    if      (key_q[3]) ctl.move = 3'd1;
    else if (key_q[2]) ctl.move = 3'd2;
    else if (key_q[1]) ctl.move = 3'd3;
    else if (key_q[0]) ctl.move = 3'd4;
    else               ctl.move = 3'd0;
  end

  assign ctl.timer_done = (timer_q == T_LAST);
  assign ctl.obs_wall   = valid_q & (oob_q | (obs_data == 2'd1));
  assign ctl.obs_lava   = valid_q & ~oob_q & (obs_data == 2'd2);
  assign ctl.obs_ice    = valid_q & ~oob_q & (obs_data == 2'd3);
  assign ctl.unfrozen   = (frz_q == FZ_MAX);
  assign obs_addr       = addr_q;
  assign vga_x          = vx_q;
  assign vga_y          = vy_q;
  assign vga_colour     = vc_q;
  assign vga_plot       = vp_q;
endmodule

// File: tb/tb_maze_datapath.sv
module tb_maze_datapath;
  localparam int GW = 20, GH = 15, TC = 8, FT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_n = 4'hF;
  logic [1:0] obs_data = 2'd0;
  logic [8:0] obs_addr;
  logic [4:0] vga_x;
  logic [3:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [1:0] rom [0:511];
  bit         armed = 1'b0;
  int         n_cmp = 0, n_bad = 0;

  maze_datapath_if ifc();

  maze_datapath #(.TICK_CYCLES(TC), .TICK_W(4), .FREEZE_TICKS(FT)) dut (
    .clk(clk), .reset(reset), .ctl(ifc), .key_n(key_n), .obs_data(obs_data),
    .obs_addr(obs_addr), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot));

  always #5 clk = ~clk;

  // Registered-read obstacle ROM.
  always @(posedge clk) obs_data <= rom[obs_addr];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: game state as plain integers.
  int m_x, m_y, m_timer, m_addr, m_wait, m_frz, m_vx, m_vy, m_vc, m_vplot;
  bit m_oob;
  logic [3:0] m_keys;
  logic [2:0] ctab [4];
  initial ctab = '{3'b000, 3'b111, 3'b011, 3'b100};

  function automatic int cls();  // 0 none, 1 wall, 2 lava, 3 ice
    if (m_wait != 0) return 0;
    if (m_oob) return 1;
    return int'(rom[m_addr]);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_x = 1; m_y = 1; m_timer = 0; m_keys = 0; m_addr = GW + 1;
      m_wait = -1; m_oob = 0; m_frz = 0; m_vx = 0; m_vy = 0; m_vc = 0; m_vplot = 0;
    end else begin
      int nx, ny, tx, ty;
      bit done, ice;
      done = (m_timer == TC - 1);
      ice  = (cls() == 3);
      m_vplot = ifc.plot;
      if (ifc.plot) begin m_vx = m_x; m_vy = m_y; m_vc = ctab[ifc.s_color]; end
      if (ifc.en_obs) begin
        tx = m_x; ty = m_y;
        case (ifc.s_obs)
          1: tx--; 2: tx++; 3: ty--; 4: ty++; default: ;
        endcase
        m_oob = (tx < 0 || tx >= GW || ty < 0 || ty >= GH);
        if (!m_oob) m_addr = ty * GW + tx;
        m_wait = (ifc.s_obs >= 1 && ifc.s_obs <= 4) ? 1 : -1;
        m_frz = 0;
      end else begin
        if (m_wait > 0) m_wait--;
        if (ice && done && ifc.en_timer && ifc.s_timer && m_frz < FT) m_frz++;
      end
      if (ifc.en_timer) m_timer = ifc.s_timer ? (m_timer + 1) % TC : 0;
      if (ifc.en_key) m_keys = ifc.s_key ? ~key_n : 4'b0;
      nx = m_x; ny = m_y;
      if (ifc.en_xpos)
        case (ifc.s_xpos) 0: nx = 1; 1: nx = (m_x < GW-1) ? m_x+1 : m_x;
                          2: nx = (m_x > 0) ? m_x-1 : 0; default: ; endcase
      if (ifc.en_ypos)
        case (ifc.s_ypos) 0: ny = 1; 1: ny = (m_y < GH-1) ? m_y+1 : m_y;
                          2: ny = (m_y > 0) ? m_y-1 : 0; default: ; endcase
      m_x = nx; m_y = ny;
    end
  end

  always @(negedge clk) if (armed) begin
    int mv;
    mv = m_keys[3] ? 1 : m_keys[2] ? 2 : m_keys[1] ? 3 : m_keys[0] ? 4 : 0;
    chk("m_timer_done", 32'(ifc.timer_done), 32'(m_timer == TC-1));
    chk("m_move",       32'(ifc.move),       32'(mv));
    chk("m_obs_addr",   32'(obs_addr),       32'(m_addr));
    chk("m_wall",       32'(ifc.obs_wall),   32'(cls() == 1));
    chk("m_lava",       32'(ifc.obs_lava),   32'(cls() == 2));
    chk("m_ice",        32'(ifc.obs_ice),    32'(cls() == 3));
    chk("m_unfrozen",   32'(ifc.unfrozen),   32'(m_frz == FT));
    chk("m_vga_plot",   32'(vga_plot),       32'(m_vplot));
    chk("m_vga_x",      32'(vga_x),          32'(m_vx));
    chk("m_vga_y",      32'(vga_y),          32'(m_vy));
    chk("m_vga_colour", 32'(vga_colour),     32'(m_vc));
  end

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 2'd0;
    rom[22] = 2'd2;  // lava right of (1,1)
    rom[84] = 2'd3;  // ice right of (3,4)
    {ifc.en_xpos, ifc.en_ypos, ifc.en_key, ifc.s_key, ifc.en_obs} = '0;
    {ifc.en_timer, ifc.s_timer, ifc.plot} = '0;
    ifc.s_xpos = 0; ifc.s_ypos = 0; ifc.s_obs = 0; ifc.s_color = 0;
    step(2);
    reset = 1'b0; armed = 1'b1;
    chk("rst_addr", 32'(obs_addr), 32'd21);
    chk("rst_plot", 32'(vga_plot), 32'd0);
    chk("rst_move", 32'(ifc.move), 32'd0);

    // Timer: done on count 7 and 15, then clear.
    ifc.en_timer = 1; ifc.s_timer = 1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("timer_done", 32'(ifc.timer_done), 32'((i % 8) == 7));
    end
    ifc.s_timer = 0; step(); ifc.en_timer = 0;
    chk("timer_clr", 32'(ifc.timer_done), 32'd0);

    // Key latch.
    key_n = 4'b0110; ifc.en_key = 1; ifc.s_key = 1; step();
    chk("move_left", 32'(ifc.move), 32'd1);
    key_n = 4'b1111; step();
    chk("move_none", 32'(ifc.move), 32'd0);
    key_n = 4'b0110; step();
    ifc.s_key = 0; step(); ifc.en_key = 0;
    chk("move_clr", 32'(ifc.move), 32'd0);

    // X saturation, observed via plot.
    ifc.en_xpos = 1; ifc.s_xpos = 2; step(2); ifc.en_xpos = 0;
    ifc.plot = 1; ifc.s_color = 1; step(); ifc.plot = 0;
    chk("x_sat_lo", 32'(vga_x), 32'd0);
    chk("col_player", 32'(vga_colour), 32'd7);
    ifc.en_xpos = 1; ifc.s_xpos = 1; step(25); ifc.en_xpos = 0;
    ifc.plot = 1; step(); ifc.plot = 0;
    chk("x_sat_hi", 32'(vga_x), 32'd19);

    // Lava lookup right of (1,1).
    ifc.en_xpos = 1; ifc.s_xpos = 0; ifc.en_ypos = 1; ifc.s_ypos = 0; step();
    ifc.en_xpos = 0; ifc.en_ypos = 0;
    ifc.en_obs = 1; ifc.s_obs = 2; step(); ifc.en_obs = 0;
    chk("lava_addr", 32'(obs_addr), 32'd22);
    chk("lava_early", 32'(ifc.obs_lava), 32'd0);
    step();
    chk("lava", 32'(ifc.obs_lava), 32'd1);
    chk("lava_wall", 32'(ifc.obs_wall), 32'd0);
    chk("lava_ice", 32'(ifc.obs_ice), 32'd0);

    // Off-grid left of (0,5).
    ifc.en_xpos = 1; ifc.s_xpos = 2; ifc.en_ypos = 1; ifc.s_ypos = 1; step(4);
    ifc.en_xpos = 0; ifc.en_ypos = 0;
    ifc.en_obs = 1; ifc.s_obs = 1; step(); ifc.en_obs = 0; step();
    chk("oob_wall", 32'(ifc.obs_wall), 32'd1);
    chk("oob_addr", 32'(obs_addr), 32'd22);

    // Move to (3,4) and plot frozen colour.
    ifc.en_xpos = 1; ifc.s_xpos = 1; ifc.en_ypos = 1; ifc.s_ypos = 2; step();
    ifc.en_ypos = 0; step(2); ifc.en_xpos = 0;
    ifc.plot = 1; ifc.s_color = 2; step(); ifc.plot = 0;
    chk("plot_strobe", 32'(vga_plot), 32'd1);
    chk("plot_x", 32'(vga_x), 32'd3);
    chk("plot_y", 32'(vga_y), 32'd4);
    chk("plot_col", 32'(vga_colour), 32'b011);
    step();
    chk("plot_idle", 32'(vga_plot), 32'd0);
    chk("plot_hold", 32'(vga_x), 32'd3);
    // Plot with same-cycle move uses the old position.
    ifc.plot = 1; ifc.en_xpos = 1; ifc.s_xpos = 1; step();
    ifc.plot = 0; ifc.s_xpos = 2; step(); ifc.en_xpos = 0;
    chk("plot_pre", 32'(vga_x), 32'd3);

    // Ice right of (3,4): unfrozen after the 2nd tick seen while on ice.
    ifc.en_obs = 1; ifc.s_obs = 2; ifc.en_timer = 1; ifc.s_timer = 0; step();
    ifc.en_obs = 0; ifc.s_timer = 1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("ice", 32'(ifc.obs_ice), 32'd1);
      chk("unfrozen", 32'(ifc.unfrozen), 32'(i >= 16));
    end
    ifc.en_timer = 0;
    ifc.en_obs = 1; ifc.s_obs = 0; step(); ifc.en_obs = 0;
    chk("unfrz_clr", 32'(ifc.unfrozen), 32'd0);
    chk("cur_addr", 32'(obs_addr), 32'd83);

    // Out-of-range select acts as current cell.
    ifc.en_obs = 1; ifc.s_obs = 5; step(); ifc.en_obs = 0; step();
    chk("sobs5_ice", 32'(ifc.obs_ice), 32'd0);

    // Reset mid-lookup.
    ifc.en_obs = 1; ifc.s_obs = 2; step(); ifc.en_obs = 0;
    reset = 1; step(); reset = 0;
    chk("abort_ice", 32'(ifc.obs_ice), 32'd0);
    chk("abort_addr", 32'(obs_addr), 32'd21);
    step(3);

    armed = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
